lfsr_scrambler: RTL and testbench

LFSR_SCRAMBLER -- requirements
Module: lfsr_scrambler

---
 rtl/lfsr_scrambler_pkg.sv | 24 ++
 rtl/lfsr_step.sv | 27 ++
 rtl/lfsr_scrambler.sv | 117 +++++++++++
 tb/tb_lfsr_scrambler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_scrambler_pkg.sv
// Shared constants for the additive/self-synchronising LFSR scrambler.
package lfsr_scrambler_pkg;

    localparam int LEN_DEF   = 20;
    localparam int TAP_A_DEF = 2;
    localparam int TAP_B_DEF = 19;

    localparam logic SCRAMBLE   = 1'b0;
    localparam logic DESCRAMBLE = 1'b1;

    // Wide enough for LEN (max 32) plus one W (max 8) before saturation.
    localparam int CNT_W = 6;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] inc,
        input logic [CNT_W-1:0] lim
    );
        logic [CNT_W-1:0] sum;
        sum = a + inc;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One serial bit step of the scrambler; purely combinational.
// The output bit formula is shared by both modes; only the bit shifted into the register differs.
module lfsr_step
    import lfsr_scrambler_pkg::*;
#(
    parameter int LEN    = LEN_DEF,
    parameter int TAP_A  = TAP_A_DEF,
    parameter int TAP_B  = TAP_B_DEF,
    parameter bit INVERT = 1'b1
) (
    input  logic [LEN-1:0] sr_in,
    input  logic           bit_in,
    input  logic           mode,
    output logic [LEN-1:0] sr_out,
    output logic           bit_out
);

    logic fb;

    always_comb begin
        fb      = sr_in[TAP_A] ^ sr_in[TAP_B];
        bit_out = bit_in ^ fb ^ INVERT;
        // Descrambler shifts in the received bit, which is what makes it self-synchronising.
        sr_out  = {sr_in[LEN-2:0], (mode == DESCRAMBLE) ? bit_in : bit_out};
    end

endmodule

// File: rtl/lfsr_scrambler.sv
// LFSR scrambler/descrambler, W bits per beat processed MSB first; one-cycle registered latency.
// Input is ready whenever the output register is empty or being drained; FLUSH/RST force not-ready.
module lfsr_scrambler
    import lfsr_scrambler_pkg::*;
#(
    parameter int LEN    = LEN_DEF,
    parameter int TAP_A  = TAP_A_DEF,
    parameter int TAP_B  = TAP_B_DEF,
    parameter int W      = 1,
    parameter bit INVERT = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         MODE,
    input  logic         BYPASS,
    input  logic         FLUSH,
    input  logic [W-1:0] IN_DATA,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [W-1:0] OUT_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic         LOCKED
);

    logic [LEN-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             locked_q, locked_d;

    logic             in_ready;
    logic             accept;
    logic [W-1:0]     step_bits;
    logic [LEN-1:0]   sr_final;

    // Step i handles IN_DATA[W-1-i], so the earliest bit sees the current register.
    for (genvar i = 0; i < W; i++) begin : g_step
        logic [LEN-1:0] sr_i;
        logic [LEN-1:0] sr_o;
        if (i == 0) begin : g_first
            assign sr_i = sr_q;
        end else begin : g_next
            assign sr_i = g_step[i-1].sr_o;
        end
        lfsr_step #(
            .LEN    (LEN),
            .TAP_A  (TAP_A),
            .TAP_B  (TAP_B),
            .INVERT (INVERT)
        ) u_step (
            .sr_in   (sr_i),
            .bit_in  (IN_DATA[W-1-i]),
            .mode    (MODE),
            .sr_out  (sr_o),
            .bit_out (step_bits[W-1-i])
        );
    end

    assign sr_final = g_step[W-1].sr_o;

    always_comb begin
        in_ready    = !RST && !FLUSH && (!out_valid_q || OUT_READY);
        accept      = IN_VALID && in_ready;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (FLUSH) begin
            sr_d        = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            mode_d      = MODE;
            out_valid_d = 1'b1;
            if (MODE != mode_q) begin
                cnt_d = '0;
            end
            if (BYPASS) begin
                out_data_d = IN_DATA;
            end else begin
                out_data_d = step_bits;
                sr_d       = sr_final;
                cnt_d      = sat_add(cnt_d, CNT_W'(W), CNT_W'(LEN));
            end
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
        locked_d = (cnt_d == CNT_W'(LEN));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            mode_q      <= SCRAMBLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            locked_q    <= locked_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign LOCKED    = locked_q;

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Self-checking bench: W=1 main instance, scrambler->descrambler loopback pair, W=8 instance.
module tb_lfsr_scrambler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (W=1)
    logic a_rst, a_mode, a_bypass, a_flush, a_in_data, a_in_valid, a_out_ready;
    logic a_in_ready, a_out_data, a_out_valid, a_locked;

    // Loopback pair
    logic lb_rst, ls_in_data, ls_in_valid;
    logic ls_in_ready, ls_out_data, ls_out_valid, ls_out_ready, ls_locked;
    logic ld_in_data, ld_in_valid, ld_in_ready, ld_out_data, ld_out_valid, ld_locked;

    // Wide instance (W=8)
    logic       b_rst, b_in_valid;
    logic [7:0] b_in_data, b_out_data;
    logic       b_in_ready, b_out_valid, b_locked;

    assign ls_out_ready = ld_in_ready;
    assign ld_in_data   = ls_out_data;
    assign ld_in_valid  = ls_out_valid;

    lfsr_scrambler u_a (
        .CLK(clk), .RST(a_rst), .MODE(a_mode), .BYPASS(a_bypass), .FLUSH(a_flush),
        .IN_DATA(a_in_data), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
        .OUT_DATA(a_out_data), .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready),
        .LOCKED(a_locked)
    );

    lfsr_scrambler u_ls (
        .CLK(clk), .RST(lb_rst), .MODE(1'b0), .BYPASS(1'b0), .FLUSH(1'b0),
        .IN_DATA(ls_in_data), .IN_VALID(ls_in_valid), .IN_READY(ls_in_ready),
        .OUT_DATA(ls_out_data), .OUT_VALID(ls_out_valid), .OUT_READY(ls_out_ready),
        .LOCKED(ls_locked)
    );

    lfsr_scrambler u_ld (
        .CLK(clk), .RST(lb_rst), .MODE(1'b1), .BYPASS(1'b0), .FLUSH(1'b0),
        .IN_DATA(ld_in_data), .IN_VALID(ld_in_valid), .IN_READY(ld_in_ready),
        .OUT_DATA(ld_out_data), .OUT_VALID(ld_out_valid), .OUT_READY(1'b1),
        .LOCKED(ld_locked)
    );

    lfsr_scrambler #(.W(8)) u_b (
        .CLK(clk), .RST(b_rst), .MODE(1'b0), .BYPASS(1'b0), .FLUSH(1'b0),
        .IN_DATA(b_in_data), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
        .OUT_DATA(b_out_data), .OUT_VALID(b_out_valid), .OUT_READY(1'b1),
        .LOCKED(b_locked)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference scrambler step: s = ~d ^ x[2] ^ x[19]; s is shifted in at the bottom.
    function automatic logic scr_bit(input logic [19:0] sr, input logic d, output logic [19:0] nsr);
        logic s;
        s   = ~d ^ sr[2] ^ sr[19];
        nsr = {sr[18:0], s};
        return s;
    endfunction

    // Main-instance model and scoreboard
    logic [19:0] ma_sr = '0;
    int          ma_cnt = 0;
    logic        ma_mode = 1'b0;
    logic        ev_vld = 1'b0;
    logic        ev_lock = 1'b0;
    logic        qa[$];
    logic        tbl_on = 1'b0;
    logic        tbl_exp = 1'b0;
    logic        collect = 1'b0;
    logic        qa_bits[$];
    logic        qb_bits[$];

    // Wide-instance model and scoreboard
    logic [19:0] mb_sr = '0;
    logic [7:0]  qb[$];

    // Loopback bookkeeping
    logic        q_src[$];
    int          lb_idx = 0;
    int          ld_acc = 0;
    logic        lb_on = 1'b0;

    task automatic cycle();
        logic       e;
        logic [7:0] eb;
        @(negedge clk);
        chk("a_in_ready", a_in_ready, !a_rst && !a_flush && (!ev_vld || a_out_ready));
        if (a_rst || a_flush) begin
            qa.delete();
            ma_sr   = '0;
            ma_cnt  = 0;
            ev_vld  = 1'b0;
            ev_lock = 1'b0;
            if (a_rst) ma_mode = 1'b0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_out_data", a_out_data, e);
                    if (collect) qa_bits.push_back(a_out_data);
                end
            end
            if (a_in_valid && a_in_ready) begin
                if (a_mode != ma_mode) ma_cnt = 0;
                ma_mode = a_mode;
                if (a_bypass) e = a_in_data;
                else begin
                    e      = scr_bit(ma_sr, a_in_data, ma_sr);
                    ma_cnt = (ma_cnt + 1 > 20) ? 20 : ma_cnt + 1;
                end
                qa.push_back(tbl_on ? tbl_exp : e);
                ev_vld = 1'b1;
            end else if (a_out_ready) begin
                ev_vld = 1'b0;
            end
            ev_lock = (ma_cnt == 20);
        end
        if (b_rst) begin
            qb.delete();
            mb_sr = '0;
        end else begin
            if (b_out_valid) begin
                if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
                else chk("w8_data", b_out_data, qb.pop_front());
                if (collect) for (int k = 7; k >= 0; k--) qb_bits.push_back(b_out_data[k]);
            end
            if (b_in_valid && b_in_ready) begin
                for (int k = 7; k >= 0; k--) eb[k] = scr_bit(mb_sr, b_in_data[k], mb_sr);
                qb.push_back(eb);
            end
        end
        if (!lb_rst) begin
            if (ls_in_valid && ls_in_ready) q_src.push_back(ls_in_data);
            if (ld_in_valid && ld_in_ready) ld_acc++;
            if (ld_out_valid) begin
                if (q_src.size() == 0) chk("lb_unexpected_out", 1, 0);
                else begin
                    e = q_src.pop_front();
                    if (lb_idx >= 20) chk("loopback", ld_out_data, e);
                    lb_idx++;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("a_out_valid", a_out_valid, ev_vld);
        chk("a_locked", a_locked, ev_lock);
        if (lb_on) chk("ld_locked", ld_locked, ld_acc >= 20);
    endtask

    typedef struct {
        logic byp;
        logic d;
        logic exp;
    } vec_t;

    initial begin
        vec_t        tbl[23];
        logic [9:0]  zexp;
        logic [9:0]  bpat;
        logic [2:0]  tail;
        logic        held;
        logic        src[800];
        int          mism;

        zexp = 10'b1110001110;
        bpat = 10'b1011001011;
        tail = 3'b001;
        for (int i = 0; i < 10; i++) tbl[i]      = '{1'b0, 1'b0, zexp[9-i]};
        for (int i = 0; i < 10; i++) tbl[10+i]   = '{1'b1, bpat[9-i], bpat[9-i]};
        for (int i = 0; i < 3; i++)  tbl[20+i]   = '{1'b0, 1'b0, tail[2-i]};

        a_rst = 1; lb_rst = 1; b_rst = 1;
        a_mode = 0; a_bypass = 0; a_flush = 0; a_in_data = 0; a_in_valid = 0; a_out_ready = 1;
        ls_in_data = 0; ls_in_valid = 0; b_in_data = 0; b_in_valid = 0;
        cycle();
        cycle();
        a_rst = 0; lb_rst = 0; b_rst = 0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_locked", a_locked, 0);
        chk("rst_in_ready", a_in_ready, 1);

        // Zero stream, bypass window, then resumed zero stream
        tbl_on = 1;
        for (int i = 0; i < 23; i++) begin
            a_bypass   = tbl[i].byp;
            a_in_data  = tbl[i].d;
            a_in_valid = 1;
            tbl_exp    = tbl[i].exp;
            cycle();
            if (i == 0) chk("first_valid_latency", a_out_valid, 1);
        end
        tbl_on = 0;
        a_bypass = 0;

        // Backpressure mid-stream
        for (int i = 0; i < 25; i++) begin
            a_in_data = 1'($urandom);
            cycle();
        end
        a_out_ready = 0;
        #1;
        chk("bp_in_ready", a_in_ready, 0);
        held = a_out_data;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_hold_data", a_out_data, held);
            a_in_data = 1'($urandom);
            #1;
            chk("bp_in_ready", a_in_ready, 0);
        end
        a_out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            a_in_data = 1'($urandom);
            cycle();
        end

        // Flush mid-stream
        chk("pre_flush_locked", a_locked, 1);
        a_flush = 1;
        #1;
        chk("flush_in_ready", a_in_ready, 0);
        cycle();
        chk("flush_out_valid", a_out_valid, 0);
        chk("flush_locked", a_locked, 0);
        a_flush = 0;
        a_in_data = 0;
        cycle();
        chk("post_flush_valid", a_out_valid, 1);
        chk("post_flush_bit", a_out_data, 1);
        a_in_valid = 0;
        cycle();
        cycle();
        chk("drain_a", qa.size(), 0);

        // Reset while a beat is held in the output register
        a_in_valid = 1;
        a_out_ready = 0;
        a_in_data = 1;
        cycle();
        a_rst = 1;
        #1;
        chk("rst_mid_in_ready", a_in_ready, 0);
        cycle();
        chk("rst_mid_valid", a_out_valid, 0);
        chk("rst_mid_data", a_out_data, 0);
        a_rst = 0;
        a_out_ready = 1;

        // Same 800-bit stream at W=1 and W=8
        for (int i = 0; i < 800; i++) src[i] = 1'($urandom);
        collect = 1;
        for (int i = 0; i < 800; i++) begin
            a_in_data  = src[i];
            a_in_valid = 1;
            b_in_valid = (i < 100);
            if (i < 100) for (int k = 0; k < 8; k++) b_in_data[7-k] = src[8*i+k];
            cycle();
        end
        a_in_valid = 0;
        b_in_valid = 0;
        cycle();
        cycle();
        collect = 0;
        chk("w1_len", qa_bits.size(), 800);
        chk("w8_len", qb_bits.size(), 800);
        mism = 0;
        for (int i = 0; i < 800 && i < qa_bits.size() && i < qb_bits.size(); i++)
            if (qa_bits[i] !== qb_bits[i]) mism++;
        chk("width_equiv_mismatches", mism, 0);

        // Loopback: scrambler into descrambler
        lb_on = 1;
        for (int i = 0; i < 2000; i++) begin
            ls_in_valid = 1;
            ls_in_data  = 1'($urandom);
            cycle();
        end
        ls_in_valid = 0;
        for (int i = 0; i < 4; i++) cycle();
        lb_on = 0;
        chk("loopback_count", lb_idx, 2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
